addsub_arbiter: RTL

- Round-robin arbiter and sequencer that shares one combinational 32-bit adder/subtractor among NREQ requesters.
- Each requester presents an operand pair and a mode over a valid/ready handshake.
- The block registers the winning request, drives the shared adder/subtractor from registers, captures its result and flags, and returns them on a single response channel tagged with the requester index.
- It sits between ALU-issuing clients and the single adder/subtractor instance.

---
 rtl/addsub_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/addsub_arbiter.sv
// Round-robin front end for one shared combinational 32-bit adder/subtractor.
// Each operation is granted in IDLE, executed in EXEC and returned in RESP.
module addsub_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   input  logic [NREQ-1:0]      req_d,
   input  logic [NREQ-1:0]      req_cin,
   input  logic [NREQ-1:0]      req_si,
   output logic [31:0]          as_a,
   output logic [31:0]          as_b,
   output logic                 as_d,
   output logic                 as_cin,
   output logic                 as_si,
   input  logic [31:0]          as_s,
   input  logic                 as_cout,
   input  logic                 as_v,
   input  logic                 as_so,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_s,
   output logic                 rsp_cout,
   output logic                 rsp_v,
   output logic                 rsp_so
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e         state_q;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] id_q;
   logic [IDW-1:0] gnt_idx;
   logic           gnt_found;
   int             scan_j;

   logic [31:0]    sel_a, sel_b;
   logic           sel_d, sel_cin, sel_si;

   logic [31:0]    as_a_q, as_b_q;
   logic           as_d_q, as_cin_q, as_si_q;
   logic           rsp_valid_q;
   logic [IDW-1:0] rsp_id_q;
   logic [31:0]    rsp_s_q;
   logic           rsp_cout_q, rsp_v_q, rsp_so_q;

   // Scan from the pointer upward, wrapping at NREQ so that non-power-of-two
   // requester counts never produce an out-of-range index.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan_j    = 0;
      if (state_q == IDLE) begin
         for (int k = 0; k < NREQ; k++) begin
            scan_j = (int'(ptr_q) + k) % NREQ;
            if (!gnt_found && req_valid[scan_j]) begin
               gnt_found = 1'b1;
               gnt_idx   = IDW'(scan_j);
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      sel_a     = '0;
      sel_b     = '0;
      sel_d     = 1'b0;
      sel_cin   = 1'b0;
      sel_si    = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         req_ready[k] = gnt_found && (gnt_idx == IDW'(k));
         if (gnt_idx == IDW'(k)) begin
            sel_a   = req_a[32*k +: 32];
            sel_b   = req_b[32*k +: 32];
            sel_d   = req_d[k];
            sel_cin = req_cin[k];
            sel_si  = req_si[k];
         end
      end
      ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         as_a_q      <= '0;
         as_b_q      <= '0;
         as_d_q      <= 1'b0;
         as_cin_q    <= 1'b0;
         as_si_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_s_q     <= '0;
         rsp_cout_q  <= 1'b0;
         rsp_v_q     <= 1'b0;
         rsp_so_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt_found) begin
                  as_a_q   <= sel_a;
                  as_b_q   <= sel_b;
                  as_d_q   <= sel_d;
                  as_cin_q <= sel_cin;
                  as_si_q  <= sel_si;
                  id_q     <= gnt_idx;
                  ptr_q    <= ptr_d;
                  state_q  <= EXEC;
               end
            end
            EXEC: begin
               rsp_s_q     <= as_s;
               rsp_cout_q  <= as_cout;
               rsp_v_q     <= as_v;
               rsp_so_q    <= as_so;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               // Operand registers are deliberately left holding their last values.
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign as_a      = as_a_q;
   assign as_b      = as_b_q;
   assign as_d      = as_d_q;
   assign as_cin    = as_cin_q;
   assign as_si     = as_si_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_s     = rsp_s_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_v     = rsp_v_q;
   assign rsp_so    = rsp_so_q;

endmodule
